// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives one external full-adder cell LSB first,
// one bit per clock, behind a start/busy/done handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             fa_A,
    output logic             fa_B,
    output logic             fa_C,
    input  logic             fa_Sum,
    input  logic             fa_Carry
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             c_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] s_next;

    // Shifting through a WIDTH+1 concatenation keeps WIDTH=1 legal.
    assign s_next = WIDTH'({fa_Sum, s_sh} >> 1);

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign fa_A = busy & a_sh[0];
    assign fa_B = busy & b_sh[0];
    assign fa_C = busy & c_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        c_reg <= Cin;
                        cnt   <= '0;
                        s_sh  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_next;
                    c_reg <= fa_Carry;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // c_reg still holds the carry into the MSB here.
                        Sum   <= s_next;
                        Cout  <= fa_Carry;
                        Ovf   <= c_reg ^ fa_Carry;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=4 instance plus a WIDTH=1 instance,
// each wired to a behavioural full-adder cell.
module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic         Cin = 1'b0;
    logic         busy, done, Cout, Ovf, fa_A, fa_B, fa_C, fa_Sum, fa_Carry;
    logic [W-1:0] Sum;

    logic start1 = 1'b0, A1 = 1'b0, B1 = 1'b0, Cin1 = 1'b0;
    logic busy1, done1, Sum1, Cout1, Ovf1, fa_A1, fa_B1, fa_C1, fa_Sum1, fa_Carry1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fa_Sum    = fa_A ^ fa_B ^ fa_C;
    assign fa_Carry  = (fa_A & fa_B) | (fa_A & fa_C) | (fa_B & fa_C);
    assign fa_Sum1   = fa_A1 ^ fa_B1 ^ fa_C1;
    assign fa_Carry1 = (fa_A1 & fa_B1) | (fa_A1 & fa_C1) | (fa_B1 & fa_C1);

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Ovf(Ovf),
        .fa_A(fa_A), .fa_B(fa_B), .fa_C(fa_C), .fa_Sum(fa_Sum), .fa_Carry(fa_Carry)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .Cin(Cin1),
        .busy(busy1), .done(done1), .Sum(Sum1), .Cout(Cout1), .Ovf(Ovf1),
        .fa_A(fa_A1), .fa_B(fa_B1), .fa_C(fa_C1), .fa_Sum(fa_Sum1), .fa_Carry(fa_Carry1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous checks: fa_* idle-low, result registers move only with done.
    logic [W-1:0] prev_sum = '0;
    logic         prev_cout = 1'b0, prev_ovf = 1'b0;
    always @(negedge clk) begin
        chk("fa_idle_zero", 32'(!busy && (fa_A | fa_B | fa_C)), 32'd0);
        chk("fa1_idle_zero", 32'(!busy1 && (fa_A1 | fa_B1 | fa_C1)), 32'd0);
        if (!rst && !done)
            chk("result_stable", 32'({Sum, Cout, Ovf}), 32'({prev_sum, prev_cout, prev_ovf}));
        prev_sum  = Sum;
        prev_cout = Cout;
        prev_ovf  = Ovf;
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        @(negedge clk);
        A = a; B = b; Cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; Cin = ~c;
        chk("busy_after_E0", 32'({busy, done}), 32'b10);
        for (int k = 1; k < W; k++) begin
            @(negedge clk);
            chk("busy_run", 32'({busy, done}), 32'b10);
        end
        @(negedge clk);
        chk("done_pulse", 32'({busy, done}), 32'b01);
        chk("sum", 32'(Sum), 32'(es));
        chk("cout", 32'(Cout), 32'(ec));
        chk("ovf", 32'(Ovf), 32'(eo));
        @(negedge clk);
        chk("back_idle", 32'({busy, done}), 32'b00);
    endtask

    task automatic do_op1(input logic a, input logic b, input logic c);
        logic es, ec;
        es = a ^ b ^ c;
        ec = (a & b) | (a & c) | (b & c);
        @(negedge clk);
        A1 = a; B1 = b; Cin1 = c; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; A1 = ~a; B1 = ~b; Cin1 = ~c;
        chk("w1_busy", 32'({busy1, done1}), 32'b10);
        @(negedge clk);
        chk("w1_done", 32'({busy1, done1}), 32'b01);
        chk("w1_result", 32'({Cout1, Sum1, Ovf1}), 32'({ec, es, c ^ ec}));
        @(negedge clk);
        chk("w1_idle", 32'({busy1, done1}), 32'b00);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int   total, sa, sb, ss;
        logic [W-1:0] es;
        logic ec, eo, any_done;
        int   t_last;

        vecs[0] = '{4'd3,  4'd5,  1'b0, 4'd8,  1'b0, 1'b1};
        vecs[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0};
        vecs[2] = '{4'd7,  4'd0,  1'b1, 4'd8,  1'b0, 1'b1};
        vecs[3] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
        vecs[4] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0};
        vecs[5] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
        vecs[6] = '{4'd4,  4'd4,  1'b0, 4'd8,  1'b0, 1'b1};
        vecs[7] = '{4'd9,  4'd6,  1'b1, 4'd0,  1'b1, 1'b0};

        // Reset state
        #2;
        chk("rst_ctrl", 32'({busy, done, busy1, done1}), 32'd0);
        chk("rst_result", 32'({Sum, Cout, Ovf}), 32'd0);
        chk("rst_fa", 32'({fa_A, fa_B, fa_C}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, vecs[i].ov);

        // Exhaustive sweep against integer and signed references
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    total = a + b + c;
                    es = total[W-1:0];
                    ec = total[W];
                    sa = (a > 7) ? a - 16 : a;
                    sb = (b > 7) ? b - 16 : b;
                    ss = sa + sb + c;
                    eo = (ss > 7) || (ss < -8);
                    do_op(W'(a), W'(b), c[0], es, ec, eo);
                end

        // start during RUN and during DONE is ignored
        @(negedge clk);
        A = 4'd3; B = 4'd5; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 4'd0; B = 4'd0;
        @(negedge clk);
        A = 4'd15; B = 4'd15; Cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_result", 32'({Cout, Sum, Ovf}), 32'({1'b0, 4'd8, 1'b1}));
        A = 4'd15; B = 4'd15; Cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        any_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            any_done |= done | busy;
            @(negedge clk);
        end
        chk("ign_no_extra_op", 32'(any_done), 32'd0);

        // start held high: one operation every W+2 cycles
        A = 4'd1; B = 4'd2; Cin = 1'b0; start = 1'b1;
        t_last = 0;
        for (int i = 0; i < 3; i++) begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 12);
            chk("held_done_seen", 32'(done), 32'd1);
            if (i > 0) chk("held_period", 32'(cyc - t_last), 32'(W + 2));
            t_last = cyc;
            case (i)
                0: begin
                    chk("held_op0", 32'({Cout, Sum, Ovf}), 32'({1'b0, 4'd3, 1'b0}));
                    A = 4'd6; B = 4'd7; Cin = 1'b1;
                end
                1: begin
                    chk("held_op1", 32'({Cout, Sum, Ovf}), 32'({1'b0, 4'd14, 1'b1}));
                    A = 4'd8; B = 4'd15; Cin = 1'b0;
                end
                default: begin
                    chk("held_op2", 32'({Cout, Sum, Ovf}), 32'({1'b1, 4'd7, 1'b1}));
                    start = 1'b0;
                end
            endcase
        end
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset after the 2nd RUN edge
        A = 4'd3; B = 4'd5; Cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ctrl", 32'({busy, done}), 32'd0);
        chk("arst_result", 32'({Sum, Cout, Ovf}), 32'd0);
        chk("arst_fa", 32'({fa_A, fa_B, fa_C}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            any_done |= done | busy;
        end
        chk("arst_no_done", 32'(any_done), 32'd0);
        do_op(4'd9, 4'd6, 1'b1, 4'd0, 1'b1, 1'b0);

        // WIDTH=1 boundary, all input combinations
        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            bits = 3'(v);
            do_op1(bits[2], bits[1], bits[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add controller that sequences one external `fullAdder` cell over WIDTH-bit operands, LSB first, one bit per clock. It sits between a requester using a start/busy/done handshake and a single shared `fullAdder` instance. It replaces a WIDTH-cell ripple chain with one cell plus shift registers.

## Interface

Parameters:
- `WIDTH`, 4, operand/result width in bits; legal range WIDTH >= 1.

Ports:
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  WIDTH  operand A; captured at the accepting edge.
- `B`  in  WIDTH  operand B; captured at the accepting edge.
- `Cin`  in  1  carry in; captured at the accepting edge.
- `busy`  out  1  high while bits are being processed (RUN).
- `done`  out  1  one-cycle pulse: result registers were just updated.
- `Sum`  out  WIDTH  registered result; holds until the next completion.
- `Cout`  out  1  registered carry out of the MSB.
- `Ovf`  out  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- `fa_A`  out  1  to the `fullAdder` A input.
- `fa_B`  out  1  to the `fullAdder` B input.
- `fa_C`  out  1  to the `fullAdder` C (carry-in) input.
- `fa_Sum`  in  1  from the `fullAdder` Sum output; combinational from the `fa_*` outputs.
- `fa_Carry`  in  1  from the `fullAdder` Carry output; combinational from the `fa_*` outputs.

## Operation

- States: IDLE, RUN, DONE. Two-bit state register.
- IDLE:
  - If `start`=1 at an edge, load `a_sh`<=A, `b_sh`<=B, `c_reg`<=Cin, `cnt`<=0, `s_sh`<=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN: combinational drive `fa_A`=`a_sh[0]`, `fa_B`=`b_sh[0]`, `fa_C`=`c_reg`. At each edge:
  - shift `a_sh` and `b_sh` right by one;
  - `s_sh` <= {`fa_Sum`, `s_sh[WIDTH-1:1]`};
  - `c_reg` <= `fa_Carry`;
  - `cnt` <= `cnt`+1.
- RUN end: on the edge where `cnt`==WIDTH-1:
  - `Sum` <= {`fa_Sum`, `s_sh[WIDTH-1:1]`};
  - `Cout` <= `fa_Carry`;
  - `Ovf` <= `c_reg` XOR `fa_Carry` (`c_reg` holds the carry into the MSB at that point);
  - go to DONE.
- DONE: `done`=1 for this one cycle; unconditionally return to IDLE at the next edge.
- `fa_A`, `fa_B` and `fa_C` are 0 in IDLE and DONE.
- `busy` = (state==RUN). `done` = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- `start` is ignored in RUN and DONE. It is not queued.
- A, B and Cin may change freely after the accepting edge.
- Arithmetic: {Cout, Sum} = A + B + Cin, modulo 2^(WIDTH+1). `cnt` width is clog2(WIDTH)+1, so WIDTH=1 is legal.
- WIDTH=1 boundary: a single RUN cycle; Ovf = Cin XOR Cout.

## Timing

- Reset (asynchronous, any time) forces:
  - state=IDLE, `busy`=0, `done`=0;
  - `Sum`=0, `Cout`=0, `Ovf`=0;
  - `fa_A`=`fa_B`=`fa_C`=0;
  - all internal shift registers and `cnt` = 0.
- Reset mid-RUN aborts the operation: no `done` pulse, and `Sum`, `Cout` and `Ovf` are cleared.
- Accepting edge E0, with `start`=1 in IDLE:
  - `busy`=1 after E0 through edge E(WIDTH).
  - `done`=1 in the cycle after E(WIDTH).
  - Result visible after E(WIDTH).
  - Back in IDLE after E(WIDTH+1).
- Latency from accepting edge to `done` high: WIDTH cycles. Throughput with `start` held high: one operation every WIDTH+2 cycles.
- Result outputs change only at the completion edge or on reset. They are stable at all other times.

## Test plan

- WIDTH=4, A=3, B=5, Cin=0, start pulsed one cycle -> `busy` high for 4 cycles, then `done` pulse; Sum=8, Cout=0, Ovf=1.
- A=15, B=1, Cin=0 -> Sum=0, Cout=1, Ovf=0. Also A=7, B=0, Cin=1 -> Sum=8, Cout=0, Ovf=1. Also A=8, B=8, Cin=0 -> Sum=0, Cout=1, Ovf=1.
- Exhaustive sweep of all 512 (A, B, Cin) combinations -> {Cout, Sum} matches A+B+Cin every time. Check Ovf against the signed reference. Check that `fa_*` are 0 whenever `busy`=0.
- `start` pulsed during RUN and during DONE, with different operands -> ignored; the result reflects the original operands only. No extra `done` pulse.
- `start` held high continuously -> `done` pulses every 6 cycles. Operands sampled at each IDLE edge.
- Assert `rst` after the 2nd RUN edge -> all outputs go to 0 immediately (asynchronously), with no `done`. After release, a new operation (A=9, B=6, Cin=1) completes with Sum=0, Cout=1, Ovf=0.
